// File: rtl/vector_mem_sequencer_if.sv
// Request/response and memory-port bundle for the vector memory sequencer.
// Latency: none, signal grouping only.
// Backpressure: none; the requester must watch busy before pulsing start.
interface vector_mem_sequencer_if #(
    parameter int LANES = 16,
    parameter int AW    = 16,
    parameter int DW    = 8
);
    logic                  start;
    logic                  store;
    logic [AW-1:0]         base;
    logic [7:0]            stride;
    logic [LANES*DW-1:0]   wvec;
    logic [LANES*DW-1:0]   rvec;
    logic                  busy;
    logic                  done;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;

    // sequencer side
    modport master (
        input  start, store, base, stride, wvec, mem_rdata,
        output rvec, busy, done, mem_en, mem_we, mem_addr, mem_wdata
    );

    // requester / memory side
    modport slave (
        output start, store, base, stride, wvec, mem_rdata,
        input  rvec, busy, done, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Strided vector load/store sequencer: one element per cycle to a synchronous RAM.
// Latency: done seen LANES+1 cycles after start for a store, LANES+2 for a load.
// Backpressure: none; start is ignored while busy, memory is assumed always ready.
module vector_mem_sequencer #(
    parameter int LANES = 16,
    parameter int AW    = 16,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    vector_mem_sequencer_if.master  bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic                  store_q;
    logic [AW-1:0]         addr_q;
    logic [7:0]            stride_q;
    logic [LANES*DW-1:0]   wvec_q;
    logic [LANES*DW-1:0]   rvec_q;
    logic [LW-1:0]         lane_q;
    logic [LW-1:0]         cap_idx;
    logic                  launch;
    logic                  cap_en;
    logic                  busy;
    logic                  done;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;

    // state register; reset wins over any pending start
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state plus all strobes, decoded straight from the current state
    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        cap_en    = 1'b0;
        cap_idx   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    launch  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_we   = store_q;
                mem_addr = addr_q;
                if (store_q) mem_wdata = wvec_q[lane_q*DW +: DW];
                // read data for lane i-1 arrives while lane i is issued
                cap_en   = !store_q && (lane_q != '0);
                cap_idx  = lane_q - 1'b1;
                if (lane_q == LAST) state_d = store_q ? DONE : WAIT;
            end
            WAIT: begin
                busy    = 1'b1;
                cap_en  = 1'b1;
                cap_idx = LAST;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    launch  = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // operand latch, running address accumulator, lane counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q  <= 1'b0;
            addr_q   <= '0;
            stride_q <= '0;
            wvec_q   <= '0;
            rvec_q   <= '0;
            lane_q   <= '0;
        end else begin
            if (launch) begin
                store_q  <= bus.store;
                addr_q   <= bus.base;
                stride_q <= bus.stride;
                wvec_q   <= bus.wvec;
                lane_q   <= '0;
            end else if (state_q == ACCESS) begin
                addr_q <= addr_q + AW'(stride_q);
                lane_q <= lane_q + 1'b1;
            end
            if (cap_en) rvec_q[cap_idx*DW +: DW] <= bus.mem_rdata;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.rvec      = rvec_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a synchronous RAM model.
// Latency: checks done at cycle 17 (store) / 18 (load) after the start edge.
// Backpressure: covers ignored start while busy and back-to-back start in DONE.
module tb_vector_mem_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [7:0]   ram  [0:65535];
    logic [7:0]   gold [0:65535];
    logic [127:0] exp_rvec;

    vector_mem_sequencer_if #(.LANES(16), .AW(16), .DW(8)) bus();

    vector_mem_sequencer #(.LANES(16), .AW(16), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // synchronous RAM: read data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one operation from a negedge and checks every access cycle.
    // Returns at the negedge inside the DONE cycle so a caller may chain.
    task automatic run_op(input logic st, input logic [15:0] b, input logic [7:0] s,
                          input logic [127:0] wv, input int poke_n, input string tag);
        int dn;
        logic [15:0] a;
        logic [15:0] la;
        bus.start  = 1'b1;
        bus.store  = st;
        bus.base   = b;
        bus.stride = s;
        bus.wvec   = wv;
        dn = 0;
        a  = b;
        for (int n = 1; n <= 30 && dn == 0; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (poke_n != 0 && n == poke_n) begin
                bus.start  = 1'b1;
                bus.store  = ~st;
                bus.base   = 16'h3000;
                bus.stride = 8'd3;
                bus.wvec   = ~wv;
            end
            if (poke_n != 0 && n == poke_n + 1) begin
                bus.start  = 1'b0;
                bus.store  = st;
                bus.base   = b;
                bus.stride = s;
                bus.wvec   = wv;
            end
            if (n <= 16) begin
                chk({tag, "_addr"}, bus.mem_addr, a);
                chk({tag, "_en"}, bus.mem_en, 1'b1);
                chk({tag, "_we"}, bus.mem_we, st);
                chk({tag, "_wdata"}, bus.mem_wdata, st ? wv[(n-1)*8 +: 8] : 8'h00);
                a = a + 16'(s);
            end else begin
                chk({tag, "_en_off"}, bus.mem_en, 1'b0);
            end
            if (bus.done) dn = n;
        end
        chk({tag, "_lat"}, dn, st ? 17 : 18);
        la = b;
        for (int i = 0; i < 16; i++) begin
            if (st) gold[la] = wv[i*8 +: 8];
            else    exp_rvec[i*8 +: 8] = gold[la];
            la = la + 16'(s);
        end
        chk({tag, "_rvec"}, bus.rvec, exp_rvec);
    endtask

    initial begin
        logic [127:0] wv;
        int dcnt;
        int ecnt;
        for (int a = 0; a < 65536; a++) begin
            ram[a]  = a[7:0];
            gold[a] = a[7:0];
        end
        exp_rvec      = '0;
        bus.start     = 1'b1;
        bus.store     = 1'b0;
        bus.base      = 16'h0100;
        bus.stride    = 8'd1;
        bus.wvec      = '0;
        bus.mem_rdata = '0;

        // reset held together with start: reset must win
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_en", bus.mem_en, 1'b0);
        chk("rst_addr", bus.mem_addr, 16'h0000);
        chk("rst_rvec", bus.rvec, 128'h0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);

        // plain load, incrementing addresses
        run_op(1'b0, 16'h0100, 8'd1, '0, 0, "ld_inc");
        chk("ld_inc_val", bus.rvec, 128'h0f0e0d0c0b0a09080706050403020100);
        @(negedge clk);
        chk("done_pulse", bus.done, 1'b0);
        chk("idle_after", bus.busy, 1'b0);

        // store across the top of the address space
        for (int i = 0; i < 16; i++) wv[i*8 +: 8] = 8'hA0 + 8'(i);
        run_op(1'b1, 16'hFFF8, 8'd1, wv, 0, "st_wrap");
        chk("st_rvec_keep", bus.rvec, 128'h0f0e0d0c0b0a09080706050403020100);
        @(negedge clk);
        chk("ram_fff8", ram[16'hFFF8], 8'hA0);
        chk("ram_ffff", ram[16'hFFFF], 8'hA7);
        chk("ram_0000", ram[16'h0000], 8'hA8);
        chk("ram_0007", ram[16'h0007], 8'hAF);
        chk("ram_0008", ram[16'h0008], 8'h08);

        // stride 4 then stride 0
        run_op(1'b0, 16'h0010, 8'd4, '0, 0, "ld_s4");
        @(negedge clk);
        run_op(1'b0, 16'h0010, 8'd0, '0, 0, "ld_s0");
        chk("ld_s0_val", bus.rvec, {16{8'h10}});
        @(negedge clk);

        // start pulsed while busy must not disturb the running load
        run_op(1'b0, 16'h0100, 8'd2, '0, 5, "ld_poke");
        chk("ld_poke_val", bus.rvec, 128'h1e1c1a18161412100e0c0a0806040200);

        // chained from DONE: round-trip the wrapped store, then a store, then a load
        run_op(1'b0, 16'hFFF8, 8'd1, '0, 0, "b2b_ld");
        chk("b2b_ld_val", bus.rvec, 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0);
        for (int i = 0; i < 16; i++) wv[i*8 +: 8] = 8'h50 + 8'(i);
        run_op(1'b1, 16'h0200, 8'd3, wv, 0, "b2b_st");
        run_op(1'b0, 16'h0200, 8'd3, '0, 0, "b2b_ld2");
        @(negedge clk);
        chk("b2b_end_busy", bus.busy, 1'b0);

        // reset in the middle of a load, at lane 7
        bus.start  = 1'b1;
        bus.store  = 1'b0;
        bus.base   = 16'h0100;
        bus.stride = 8'd1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        chk("abort_lane7", bus.mem_addr, 16'h0107);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en", bus.mem_en, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_rvec", bus.rvec, 128'h0);
        chk("abort_addr", bus.mem_addr, 16'h0000);
        rst  = 1'b0;
        dcnt = 0;
        ecnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.done)   dcnt++;
            if (bus.mem_en) ecnt++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_no_strobe", ecnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
